// File: rtl/axis_frame_arb.sv
// Frame-aware round-robin arbiter: one grant per frame from S_COUNT AXI-stream sources,
// feeding a single registered output stage that tags each beat with its source index.
module axis_frame_arb #(
    parameter int S_COUNT    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          grant_valid,
    output logic [ID_WIDTH-1:0]           grant_index
);
    localparam int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gidx;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    logic            g_valid;
    logic            g_last;
    logic            out_free;
    logic            xfer;

    // Modulo-S_COUNT add that also works for non-power-of-2 source counts.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= S_COUNT) s = s - S_COUNT;
        return IW'(s);
    endfunction

    // Scan downward so the closest index at or above rr_ptr is the last one written.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = S_COUNT - 1; k >= 0; k--) begin
            if (s_axis_tvalid[wrap_add(rr_ptr, k)]) begin
                pick_found = 1'b1;
                pick_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    assign g_valid  = (state == GRANT) && s_axis_tvalid[gidx];
    assign g_last   = s_axis_tlast[gidx];
    assign out_free = m_axis_tready || !m_axis_tvalid;
    assign xfer     = g_valid && out_free;

    always_comb begin
        s_axis_tready = '0;
        if (state == GRANT) s_axis_tready[gidx] = out_free;
    end

    assign grant_index = ID_WIDTH'(gidx);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gidx          <= '0;
            grant_valid   <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        gidx        <= pick_idx;
                        grant_valid <= 1'b1;
                    end
                end
                GRANT: begin
                    if (xfer && g_last) begin
                        state       <= IDLE;
                        gidx        <= '0;
                        grant_valid <= 1'b0;
                        rr_ptr      <= wrap_add(gidx, 1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (xfer)               m_axis_tvalid <= 1'b1;
            else if (m_axis_tready) m_axis_tvalid <= 1'b0;
        end
    end

    // Payload needs no reset: it is only looked at while m_axis_tvalid is high.
    always_ff @(posedge clk) begin
        if (xfer) begin
            m_axis_tdata <= s_axis_tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tlast <= g_last;
            m_axis_tuser <= s_axis_tuser[int'(gidx)*USER_WIDTH +: USER_WIDTH];
            m_axis_tid   <= ID_WIDTH'(gidx);
        end
    end
endmodule

// File: tb/tb_axis_frame_arb.sv
// Randomised + directed bench for axis_frame_arb, checked every cycle against a
// frame-level model of the arbiter (current grant, pointer, one output slot).
module tb_axis_frame_arb;
    localparam int S = 4, DW = 8, UW = 1, IDW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [S*DW-1:0]   s_axis_tdata;
    logic [S-1:0]      s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [S*UW-1:0]   s_axis_tuser;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [IDW-1:0]    m_axis_tid;
    logic [UW-1:0]     m_axis_tuser;
    logic              grant_valid;
    logic [IDW-1:0]    grant_index;

    always #5 clk = ~clk;

    axis_frame_arb #(.S_COUNT(S), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ID_WIDTH(IDW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid), .m_axis_tuser(m_axis_tuser),
        .grant_valid(grant_valid), .grant_index(grant_index)
    );

    int checks = 0, errors = 0;

    // model: current grant (-1 = none), rr pointer, one output slot
    int        mg, mrr, mtid;
    bit        mov, ml, mu;
    logic [7:0] md;

    // source generators
    bit        sv[S], sl[S], acc[S], rnd[S];
    logic [7:0] sd[S], dbase[S];
    int        beat[S], len[S], frames[S], maxf[S], gap[S], gap_at[S];

    bit        mrdy, rnd_rdy, cmp_en, prev_gv;
    bit        rdy_q[$];
    int        glog[$];
    logic [7:0] olog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < S; i++) begin
            s_axis_tvalid[i]         = sv[i];
            s_axis_tdata[i*DW +: DW] = sd[i];
            s_axis_tlast[i]          = sl[i];
            s_axis_tuser[i]          = ^sd[i];
        end
    endtask

    task automatic reset_src();
        for (int i = 0; i < S; i++) begin
            sv[i] = 0; sl[i] = 0; acc[i] = 0; rnd[i] = 0; sd[i] = '0; dbase[i] = '0;
            beat[i] = 0; len[i] = 1; frames[i] = 0; maxf[i] = 0; gap[i] = 0; gap_at[i] = 0;
        end
    endtask

    task automatic update_sources();
        for (int i = 0; i < S; i++) begin
            if (acc[i]) begin
                if (sl[i]) begin
                    frames[i]++;
                    beat[i] = 0;
                    if (rnd[i]) begin
                        len[i]   = $urandom_range(1, 4);
                        dbase[i] = 8'($urandom);
                    end
                end else begin
                    beat[i]++;
                end
                sv[i] = 0;
            end
            if (!sv[i]) begin
                if (gap[i] > 0 && beat[i] == gap_at[i]) gap[i]--;
                else if (frames[i] < maxf[i] && (!rnd[i] || ($urandom % 3) != 0)) sv[i] = 1;
            end
            sd[i] = dbase[i] + 8'(beat[i]);
            sl[i] = (beat[i] == len[i] - 1);
        end
        drive();
    endtask

    // One clock: compare DUT against model at negedge, advance model, re-drive at posedge+1.
    task automatic cycle();
        bit [S-1:0] er;
        int ng, nrr, g;
        bit nov, found;
        if (rdy_q.size() > 0) mrdy = rdy_q.pop_front();
        else if (rnd_rdy)     mrdy = ($urandom % 4) != 0;
        else                  mrdy = 1;
        m_axis_tready = mrdy;
        @(negedge clk);
        for (int i = 0; i < S; i++) er[i] = (mg == i) && (mrdy || !mov);
        if (cmp_en) begin
            chk("s_tready", 32'(s_axis_tready), 32'(er));
            chk("m_tvalid", 32'(m_axis_tvalid), 32'(mov));
            chk("grant_valid", 32'(grant_valid), 32'(mg >= 0));
            chk("grant_index", 32'(grant_index), (mg >= 0) ? 32'(mg) : 32'd0);
            if (mov) begin
                chk("m_tdata", 32'(m_axis_tdata), 32'(md));
                chk("m_tlast", 32'(m_axis_tlast), 32'(ml));
                chk("m_tid", 32'(m_axis_tid), 32'(mtid));
                chk("m_tuser", 32'(m_axis_tuser), 32'(mu));
            end
        end
        if (m_axis_tvalid === 1'b1 && mrdy) olog.push_back(m_axis_tdata);
        if (grant_valid === 1'b1 && !prev_gv) glog.push_back(int'(grant_index));
        prev_gv = (grant_valid === 1'b1);

        ng = mg; nrr = mrr; nov = mov;
        for (int i = 0; i < S; i++) acc[i] = 0;
        if (rst) begin
            ng = -1; nrr = 0; nov = 0;
        end else if (mg < 0) begin
            found = 0;
            for (int k = 0; k < S; k++)
                if (!found && sv[(mrr + k) % S]) begin found = 1; ng = (mrr + k) % S; end
            if (mrdy) nov = 0;
        end else begin
            g = mg;
            acc[g] = sv[g] && er[g];
            if (acc[g]) begin
                nov = 1; md = sd[g]; ml = sl[g]; mtid = g; mu = ^sd[g];
                if (sl[g]) begin ng = -1; nrr = (g + 1) % S; end
            end else if (mrdy) nov = 0;
        end
        @(posedge clk); #1;
        mg = ng; mrr = nrr; mov = nov;
        cmp_en = 1;
        update_sources();
    endtask

    task automatic do_reset();
        rst = 1;
        cycle(); cycle();
        rst = 0;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < S; i++) if (frames[i] < maxf[i]) return 0;
        return 1;
    endfunction

    task automatic run_done(input string name, input int budget);
        int n = 0;
        while (!all_done() && n < budget) begin cycle(); n++; end
        chk({name, "_timeout"}, 32'(all_done()), 32'd1);
        cycle(); cycle();
    endtask

    initial begin
        int exp_g[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        int bad, n;
        mg = -1; mrr = 0; mov = 0; md = '0; ml = 0; mtid = 0; mu = 0;
        cmp_en = 0; prev_gv = 0; rnd_rdy = 0; mrdy = 1;
        reset_src(); drive();
        m_axis_tready = 1;

        do_reset();
        chk("rst_grant_valid", 32'(grant_valid), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);

        // single 3-beat frame from src1
        dbase[1] = 8'h11; len[1] = 3; maxf[1] = 1;
        update_sources();
        cycle();
        chk("sf_grant_valid", 32'(grant_valid), 32'd1);
        chk("sf_grant_index", 32'(grant_index), 32'd1);
        chk("sf_tready1", 32'(s_axis_tready), 32'h2);
        cycle();
        chk("sf_beat0", 32'(m_axis_tdata), 32'h11);
        chk("sf_tid", 32'(m_axis_tid), 32'd1);
        chk("sf_last0", 32'(m_axis_tlast), 32'd0);
        cycle();
        chk("sf_beat1", 32'(m_axis_tdata), 32'h12);
        cycle();
        chk("sf_beat2", 32'(m_axis_tdata), 32'h13);
        chk("sf_last2", 32'(m_axis_tlast), 32'd1);
        chk("sf_grant_drop", 32'(grant_valid), 32'd0);
        cycle();
        chk("sf_out_empty", 32'(m_axis_tvalid), 32'd0);

        // fairness, then only src0/src2 after src3's frame
        do_reset(); reset_src();
        for (int i = 0; i < S; i++) begin dbase[i] = 8'(i * 16); len[i] = 2; end
        maxf[0] = 3; maxf[1] = 2; maxf[2] = 3; maxf[3] = 2;
        glog.delete();
        update_sources();
        run_done("rr", 300);
        chk("rr_count", 32'(glog.size()), 32'd10);
        for (int i = 0; i < 10; i++)
            if (i < glog.size()) chk($sformatf("rr_order%0d", i), 32'(glog[i]), 32'(exp_g[i]));

        // backpressure during a 4-beat frame from src2
        reset_src();
        dbase[2] = 8'hA0; len[2] = 4; maxf[2] = 1;
        olog.delete();
        rdy_q = '{1, 1, 0, 0, 1, 1, 1, 1};
        update_sources();
        run_done("bp", 50);
        chk("bp_count", 32'(olog.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < olog.size()) chk($sformatf("bp_beat%0d", i), 32'(olog[i]), 32'(8'hA0 + i));

        // mid-frame valid gap by src0 while src1 waits
        reset_src();
        dbase[0] = 8'h50; len[0] = 4; maxf[0] = 1; gap[0] = 3; gap_at[0] = 2;
        dbase[1] = 8'h60; len[1] = 1; maxf[1] = 1;
        glog.delete();
        update_sources();
        bad = 0; n = 0;
        while (!all_done() && n < 50) begin
            cycle(); n++;
            if (frames[0] == 0 && s_axis_tready[1]) bad++;
        end
        chk("gap_timeout", 32'(all_done()), 32'd1);
        chk("gap_src1_starved", 32'(bad), 32'd0);
        chk("gap_order_n", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("gap_first", 32'(glog[0]), 32'd0);
            chk("gap_second", 32'(glog[1]), 32'd1);
        end
        cycle(); cycle();

        // reset while src3 is at beat 2
        reset_src();
        dbase[3] = 8'h30; len[3] = 6; maxf[3] = 1;
        update_sources();
        n = 0;
        while (beat[3] != 2 && n < 30) begin cycle(); n++; end
        chk("mr_reach_beat2", 32'(beat[3]), 32'd2);
        rst = 1;
        cycle();
        chk("mr_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mr_grant_valid", 32'(grant_valid), 32'd0);
        chk("mr_s_tready", 32'(s_axis_tready), 32'd0);
        rst = 0;
        reset_src();
        dbase[0] = 8'h40; maxf[0] = 1; dbase[3] = 8'h70; maxf[3] = 1;
        update_sources();
        cycle();
        chk("mr_regrant_index", 32'(grant_index), 32'd0);
        chk("mr_regrant_valid", 32'(grant_valid), 32'd1);
        run_done("mr", 30);

        // random traffic with random backpressure
        reset_src();
        for (int i = 0; i < S; i++) begin
            rnd[i] = 1; maxf[i] = 100000; len[i] = $urandom_range(1, 4); dbase[i] = 8'($urandom);
        end
        rnd_rdy = 1;
        update_sources();
        for (int c = 0; c < 3000; c++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_frame_arb.md
Name: axis_frame_arb

Overview:
- Frame-aware round-robin arbiter that shares one AXI-stream FIFO write port between S_COUNT upstream sources.
- A grant is held for a whole frame, through the beat with tlast, so frames never interleave inside the downstream frame FIFO.
- The source index is forwarded on m_axis_tid for routing after the FIFO.

Parameters:
- S_COUNT, 4, number of input streams (2..16)
- DATA_WIDTH, 8, tdata width per stream
- USER_WIDTH, 1, tuser width per stream
- ID_WIDTH, 4, m_axis_tid width; must be >= clog2(S_COUNT)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata  in  S_COUNT*DATA_WIDTH  flattened input data; source i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  in  S_COUNT  per-source valid
- s_axis_tready  out  S_COUNT  per-source ready
- s_axis_tlast  in  S_COUNT  per-source end of frame
- s_axis_tuser  in  S_COUNT*USER_WIDTH  per-source user sideband
- m_axis_tdata  out  DATA_WIDTH  output data (registered)
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready (FIFO s_axis_tready)
- m_axis_tlast  out  1  output end of frame
- m_axis_tid  out  ID_WIDTH  index of source of current beat, zero-extended
- m_axis_tuser  out  USER_WIDTH  output user
- grant_valid  out  1  arbiter currently holds a grant
- grant_index  out  ID_WIDTH  granted source index; 0 when grant_valid=0

Behaviour:
- Reset values: s_axis_tready=0, m_axis_tvalid=0, grant_valid=0, grant_index=0, round-robin pointer rr_ptr=0, state=IDLE. m_axis_tdata, m_axis_tlast, m_axis_tuser and m_axis_tid are don't-care while m_axis_tvalid=0.
- State IDLE:
  - s_axis_tready is all zeros.
  - If any tvalid is set, choose the first set bit scanning upward from rr_ptr, wrapping modulo S_COUNT.
  - Next cycle: grant_valid=1, grant_index=chosen source, state=GRANT.
  - One-cycle arbitration latency from tvalid to the first possible ready.
- State GRANT, granted source g:
  - s_axis_tready[g] = m_axis_tready OR NOT m_axis_tvalid. All other tready bits are 0.
  - A transfer occurs when tvalid[g] and tready[g] are both high.
- Output stage: single register.
  - On an input transfer, the beat (data, last, user, tid=g) is loaded and m_axis_tvalid=1 at the next edge.
  - If an output handshake happens with no input transfer, m_axis_tvalid goes to 0.
  - Input-to-output latency is 1 cycle. Full throughput while m_axis_tready=1.
- Frame end: on a transfer with tlast[g]=1:
  - next state IDLE, grant_valid=0, rr_ptr=(g+1) mod S_COUNT.
  - Back-to-back frames therefore have exactly one idle arbitration cycle between them.
- Mid-frame tvalid deassertion by g: the grant is held indefinitely and no other source is served.
- Simultaneous requests: winner is the lowest index >= rr_ptr, otherwise wrap to the lowest index overall.
- Only one requester: it is re-granted after each frame, with a 1-cycle gap.
- Backpressure: while m_axis_tvalid=1 and m_axis_tready=0, the output register holds stable and tready[g]=0. No beat is lost or duplicated.
- Requests arriving during GRANT are ignored until the next IDLE.
- Reset mid-frame: all state returns to reset values at the next edge. A partially forwarded frame is truncated; the downstream FIFO is reset together with this block.
- Width rules:
  - rr_ptr and grant_index are clog2(S_COUNT) bits internally and are zero-extended onto ID_WIDTH outputs.
  - Pointer increment wraps from S_COUNT-1 to 0, including for non-power-of-2 S_COUNT.

Test Plan:
- Single frame: rst, then src1 sends 3 beats 0x11, 0x12, 0x13 (last on 0x13), m_axis_tready=1.
  - grant_index=1 one cycle after tvalid.
  - m_axis shows 0x11, 0x12, 0x13 on consecutive cycles, tid=1, tlast only on 0x13.
  - grant_valid=0 afterwards.
- Round-robin fairness: all 4 sources continuously send 2-beat frames.
  - Grant order is 0,1,2,3,0,1.
  - Each frame is contiguous on the output, with one bubble between frames.
- Priority wrap: after src3's frame ends, only src0 and src2 request.
  - src0 is granted (rr_ptr=0), then src2.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat frame from src2 (0xA0..0xA3).
  - Output holds each beat while ready=0.
  - The exact sequence 0xA0..0xA3 appears with no drops or duplicates.
  - tready[2]=0 in stalled cycles.
- Mid-frame gap: src0 drops tvalid for 3 cycles mid-frame while src1 requests.
  - src1 sees no tready until src0's tlast beat is accepted.
- Reset mid-frame: assert rst while src3 is at beat 2.
  - Next cycle m_axis_tvalid=0, grant_valid=0, all tready=0.
  - After release, src0 and src3 requesting together grants src0.
